// File: rtl/gradient_map_scheduler_pkg.sv
// Shared types for the gradient-map scheduler: FSM states, RMW op kinds and
// the default cell format.
package gmap_pkg;

    localparam int CELL_BITS = 8;

    typedef enum logic [1:0] {ARB, WR, CLR} state_e;
    typedef enum logic {EVENT, DECAY} op_e;

    typedef logic signed [CELL_BITS-1:0] cell_t;

    localparam cell_t VAL_MAX = {1'b0, {(CELL_BITS-1){1'b1}}};
    localparam cell_t VAL_MIN = {1'b1, {(CELL_BITS-1){1'b0}}};

endpackage

// File: rtl/gradient_map_scheduler_if.sv
// Event-request and map-RAM bus between the scheduler and its surroundings.
interface gradient_map_scheduler_if #(
    parameter int GRID_BITS = 4,
    parameter int VAL_BITS  = 8
);
    logic [GRID_BITS-1:0]        ev_x;
    logic [GRID_BITS-1:0]        ev_y;
    logic                        ev_pol;
    logic                        ev_valid;
    logic                        ev_ready;
    logic [2*GRID_BITS-1:0]      mem_addr;
    logic                        mem_rd_en;
    logic signed [VAL_BITS-1:0]  mem_rdata;
    logic                        mem_wr_en;
    logic signed [VAL_BITS-1:0]  mem_wdata;

    modport master (
        input  ev_x, ev_y, ev_pol, ev_valid, mem_rdata,
        output ev_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport slave (
        output ev_x, ev_y, ev_pol, ev_valid, mem_rdata,
        input  ev_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/gradient_map_scheduler_alu.sv
// Cell update for one RMW: saturating +/-1 for events, magnitude-proportional
// decay toward zero (minimum step 1) for the sweep.
module gmap_cell_alu
    import gmap_pkg::*;
#(
    parameter int VAL_BITS    = 8,
    parameter int DECAY_SHIFT = 3
) (
    input  op_e                        op,
    input  logic                       pol,
    input  logic signed [VAL_BITS-1:0] old_val,
    output logic signed [VAL_BITS-1:0] new_val
);
    localparam logic signed [VAL_BITS-1:0] VMAX = {1'b0, {(VAL_BITS-1){1'b1}}};
    localparam logic signed [VAL_BITS-1:0] VMIN = {1'b1, {(VAL_BITS-1){1'b0}}};

    // One extra bit so that |VMIN| is representable.
    logic signed [VAL_BITS:0] ext, mag, step, sum;

    always_comb begin
        ext  = {old_val[VAL_BITS-1], old_val};
        mag  = old_val[VAL_BITS-1] ? -ext : ext;
        step = mag >>> DECAY_SHIFT;
        if (step == '0)
            step = {{VAL_BITS{1'b0}}, 1'b1};
        sum  = old_val[VAL_BITS-1] ? ext + step : ext - step;

        new_val = old_val;
        if (op == EVENT) begin
            if (pol)
                new_val = (old_val == VMAX) ? VMAX : old_val + VAL_BITS'(1);
            else
                new_val = (old_val == VMIN) ? VMIN : old_val - VAL_BITS'(1);
        end else if (old_val != '0) begin
            new_val = VAL_BITS'(sum);
        end
    end
endmodule

// File: rtl/gradient_map_scheduler.sv
// Single-port gradient-map RAM arbiter: event RMW, periodic decay sweep RMW and
// a full-map clear, with round-robin between events and decay.
module gradient_map_scheduler
    import gmap_pkg::*;
#(
    parameter int GRID_BITS    = 4,
    parameter int VAL_BITS     = 8,
    parameter int DECAY_PERIOD = 65536,
    parameter int DECAY_SHIFT  = 3
) (
    input  logic clk,
    input  logic rst,
    gradient_map_scheduler_if.master bus,
    input  logic clear_req,
    output logic sweep_active,
    output logic clear_busy,
    output logic sweep_done,
    output logic decay_overrun
);
    localparam int AW = 2 * GRID_BITS;
    localparam int TW = $clog2(DECAY_PERIOD);
    localparam logic [AW-1:0] LAST = '1;

    state_e                     state_q, state_nx;
    op_e                        op_q, last_grant;
    logic                       pol_q;
    logic [AW-1:0]              addr_q, sweep_ptr;
    logic [TW-1:0]              timer;
    logic                       decay_pending, clear_pending;
    logic                       tick, dreq, ev_gnt, dc_gnt, clr_gnt;
    logic signed [VAL_BITS-1:0] alu_out;

    gmap_cell_alu #(.VAL_BITS(VAL_BITS), .DECAY_SHIFT(DECAY_SHIFT)) u_alu (
        .op      (op_q),
        .pol     (pol_q),
        .old_val (bus.mem_rdata),
        .new_val (alu_out)
    );

    assign tick          = (timer == TW'(DECAY_PERIOD - 1));
    assign decay_overrun = tick & (decay_pending | sweep_active);

    always_comb begin
        state_nx      = state_q;
        dreq          = decay_pending | sweep_active;
        ev_gnt        = 1'b0;
        dc_gnt        = 1'b0;
        clr_gnt       = 1'b0;
        bus.ev_ready  = 1'b0;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        sweep_done    = 1'b0;
        clear_busy    = 1'b0;
        // Gated by rst so outputs fall the moment reset asserts, even mid-RMW.
        if (!rst) begin
            case (state_q)
                ARB: begin
                    if (clear_pending || clear_req) begin
                        clr_gnt  = 1'b1;
                        state_nx = CLR;
                    end else if (bus.ev_valid && (!dreq || last_grant == DECAY)) begin
                        ev_gnt        = 1'b1;
                        bus.ev_ready  = 1'b1;
                        bus.mem_rd_en = 1'b1;
                        bus.mem_addr  = {bus.ev_y, bus.ev_x};
                        state_nx      = WR;
                    end else if (dreq) begin
                        dc_gnt        = 1'b1;
                        bus.mem_rd_en = 1'b1;
                        bus.mem_addr  = sweep_ptr;
                        state_nx      = WR;
                    end
                end
                WR: begin
                    bus.mem_wr_en = 1'b1;
                    bus.mem_addr  = addr_q;
                    bus.mem_wdata = alu_out;
                    sweep_done    = (op_q == DECAY) && (addr_q == LAST);
                    state_nx      = ARB;
                end
                CLR: begin
                    bus.mem_wr_en = 1'b1;
                    bus.mem_addr  = addr_q;
                    clear_busy    = 1'b1;
                    if (addr_q == LAST)
                        state_nx = ARB;
                end
                default: state_nx = ARB;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB;
            op_q          <= EVENT;
            last_grant    <= EVENT;
            pol_q         <= 1'b0;
            addr_q        <= '0;
            sweep_ptr     <= '0;
            timer         <= '0;
            decay_pending <= 1'b0;
            clear_pending <= 1'b0;
            sweep_active  <= 1'b0;
        end else begin
            state_q <= state_nx;
            timer   <= tick ? '0 : timer + TW'(1);

            if (clr_gnt)
                clear_pending <= 1'b0;
            else if (clear_req)
                clear_pending <= 1'b1;

            if (ev_gnt) begin
                op_q       <= EVENT;
                pol_q      <= bus.ev_pol;
                addr_q     <= {bus.ev_y, bus.ev_x};
                last_grant <= EVENT;
            end
            if (dc_gnt) begin
                op_q          <= DECAY;
                addr_q        <= sweep_ptr;
                last_grant    <= DECAY;
                sweep_active  <= 1'b1;
                decay_pending <= 1'b0;
            end
            if (state_q == CLR)
                addr_q <= addr_q + AW'(1);

            if (state_q == WR && op_q == DECAY) begin
                if (addr_q == LAST) begin
                    sweep_ptr    <= '0;
                    sweep_active <= 1'b0;
                end else begin
                    sweep_ptr <= sweep_ptr + AW'(1);
                end
            end

            // A clear abandons the sweep; the timer keeps running regardless.
            if (clr_gnt) begin
                addr_q        <= '0;
                sweep_ptr     <= '0;
                sweep_active  <= 1'b0;
                decay_pending <= 1'b0;
            end
            if (tick && !decay_pending && !sweep_active)
                decay_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gradient_map_scheduler.sv
// Bench for gradient_map_scheduler: u_a (long decay period) for event, clear and
// reset behaviour, u_b (decay period 16) for sweep, overrun and arbitration.
module tb_gradient_map_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, clr_a, clr_b;
    logic sa_a, cb_a, sd_a, ov_a, sa_b, cb_b, sd_b, ov_b;

    gradient_map_scheduler_if bus_a ();
    gradient_map_scheduler_if bus_b ();

    gradient_map_scheduler #(.DECAY_PERIOD(65536)) u_a (
        .clk(clk), .rst(rst_a), .bus(bus_a), .clear_req(clr_a),
        .sweep_active(sa_a), .clear_busy(cb_a), .sweep_done(sd_a), .decay_overrun(ov_a)
    );

    gradient_map_scheduler #(.DECAY_PERIOD(16)) u_b (
        .clk(clk), .rst(rst_b), .bus(bus_b), .clear_req(clr_b),
        .sweep_active(sa_b), .clear_busy(cb_b), .sweep_done(sd_b), .decay_overrun(ov_b)
    );

    // RAM models: synchronous read, write visible to the next cycle's read.
    bit signed [7:0] mem_a [256];
    bit signed [7:0] mem_b [256];
    logic            pl_en, pl_sel;
    logic [7:0]      pl_addr;
    logic signed [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem_a[pl_addr] <= pl_data;
        else if (bus_a.mem_wr_en) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        if (bus_a.mem_rd_en) bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
        if (pl_en && pl_sel) mem_b[pl_addr] <= pl_data;
        else if (bus_b.mem_wr_en) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        if (bus_b.mem_rd_en) bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic preload(input logic sel, input logic [7:0] a, input logic signed [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
    endtask

    typedef struct {
        logic [3:0] x, y;
        logic       pol;
        int         addr;
        int         wdata;
    } vec_t;
    vec_t tv [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got [4];
        int got255, first_rd, ov_cnt, ov_idle, ov_dbl, bad, busy, sd_cnt, sa_cnt, rdy_cnt, dur, start_cyc, alt_err;
        bit ov_prev, done_ok, seen, started, prev_d;

        rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
        bus_a.ev_x = '0; bus_a.ev_y = '0; bus_a.ev_pol = 1'b0; bus_a.ev_valid = 1'b0;
        bus_b.ev_x = '0; bus_b.ev_y = '0; bus_b.ev_pol = 1'b0; bus_b.ev_valid = 1'b0;
        #1; rst_a = 1'b1; rst_b = 1'b1;

        // ---- reset state, with a request already waiting ----
        @(negedge clk); bus_a.ev_valid = 1'b1; #1;
        chk("rst_ev_ready", bus_a.ev_ready, 0);
        chk("rst_rd_en", bus_a.mem_rd_en, 0);
        chk("rst_wr_en", bus_a.mem_wr_en, 0);
        chk("rst_addr", bus_a.mem_addr, 0);
        chk("rst_status_a", {sa_a, cb_a, sd_a, ov_a}, 0);
        chk("rst_status_b", {sa_b, cb_b, sd_b, ov_b, bus_b.mem_wr_en}, 0);
        bus_a.ev_valid = 1'b0;

        preload(1, 8'h00, 100);  preload(1, 8'h01, -5);
        preload(1, 8'h02, 1);    preload(1, 8'h03, 0);
        preload(1, 8'hFF, -128);
        preload(0, 8'h53, 7);    preload(0, 8'h10, -128);
        preload(0, 8'h22, 127);  preload(0, 8'h34, -1);
        preload(0, 8'hFF, -127);
        @(negedge clk); pl_en = 1'b0;

        // ---- u_b: first decay sweep ----
        @(negedge clk); rst_b = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = 999;
        got255 = 999; first_rd = -1; ov_cnt = 0; ov_idle = 0; ov_dbl = 0;
        ov_prev = 0; done_ok = 0; seen = 0; sa_cnt = 0;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk); #1;
            if (bus_b.mem_rd_en && first_rd < 0) first_rd = bus_b.mem_addr;
            if (bus_b.mem_wr_en && bus_b.mem_addr < 4) got[bus_b.mem_addr] = bus_b.mem_wdata;
            if (bus_b.mem_wr_en && bus_b.mem_addr == 255) got255 = bus_b.mem_wdata;
            if (sa_b) sa_cnt++;
            if (ov_b) begin
                ov_cnt++;
                if (!sa_b) ov_idle++;
                if (ov_prev) ov_dbl++;
            end
            ov_prev = ov_b;
            if (sd_b) begin
                seen = 1;
                done_ok = bus_b.mem_wr_en && bus_b.mem_addr == 255;
                break;
            end
        end
        chk("decay_first_addr", first_rd, 0);
        chk("decay_100", got[0], 88);
        chk("decay_m5", got[1], -4);
        chk("decay_1", got[2], 0);
        chk("decay_0", got[3], 0);
        chk("decay_m128", got255, -112);
        chk("sweep_done_seen", seen, 1);
        chk("sweep_done_with_last_wr", done_ok, 1);
        chk("sweep_active_seen", sa_cnt > 400, 1);
        chk("overrun_seen", ov_cnt > 0, 1);
        chk("overrun_idle", ov_idle, 0);
        chk("overrun_one_cycle", ov_dbl, 0);

        // ---- u_b: events contending with a sweep ----
        @(negedge clk);
        bus_b.ev_x = 4'd5; bus_b.ev_y = 4'd9; bus_b.ev_pol = 1'b1; bus_b.ev_valid = 1'b1;
        #1;
        chk("post_sweep_active", sa_b, 0);
        chk("post_sweep_done", sd_b, 0);
        started = 0; prev_d = 0; alt_err = 0; bad = 0; dur = 0; start_cyc = 0;
        for (int c = 0; c < 1300; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (bus_b.mem_rd_en) begin
                if (bus_b.ev_ready && bus_b.mem_addr != 8'h95) bad++;
                if (!started && !bus_b.ev_ready) begin
                    started = 1; start_cyc = c; prev_d = 1;
                    if (bus_b.mem_addr != 0) bad++;
                end else if (started) begin
                    if (prev_d == !bus_b.ev_ready) alt_err++;
                    prev_d = !bus_b.ev_ready;
                end
            end
            if (started && sd_b) begin dur = c - start_cyc + 1; break; end
        end
        chk("alt_pattern_errors", alt_err, 0);
        chk("alt_addr_errors", bad, 0);
        chk("alt_sweep_within_1024", (dur > 0) && (dur <= 1024), 1);
        chk("alt_sweep_min_len", dur >= 1000, 1);
        bus_b.ev_valid = 1'b0;

        // ---- u_b: clear in the middle of a sweep ----
        seen = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk); #1;
            if (bus_b.mem_rd_en && !bus_b.ev_ready && bus_b.mem_addr == 40) begin seen = 1; break; end
        end
        chk("clr_mid_found_ptr40", seen, 1);
        @(negedge clk); clr_b = 1'b1; #1;
        chk("clr_mid_wr_completes", bus_b.mem_wr_en, 1);
        chk("clr_mid_wr_addr", bus_b.mem_addr, 40);
        @(negedge clk); clr_b = 1'b0; #1;
        for (int w = 0; w < 4 && !cb_b; w++) begin @(negedge clk); #1; end
        busy = 0; bad = 0; sd_cnt = 0; sa_cnt = 0;
        while (cb_b && busy < 300) begin
            if (!(bus_b.mem_wr_en && !bus_b.mem_rd_en && bus_b.mem_wdata == 0 &&
                  bus_b.mem_addr == busy[7:0])) bad++;
            if (sd_b) sd_cnt++;
            if (sa_b) sa_cnt++;
            busy++;
            @(negedge clk); #1;
        end
        chk("clr_mid_busy_cycles", busy, 256);
        chk("clr_mid_bad_writes", bad, 0);
        chk("clr_mid_no_sweep_done", sd_cnt, 0);
        chk("clr_mid_sweep_dropped", sa_cnt, 0);
        first_rd = -1;
        for (int w = 0; w < 40; w++) begin
            if (bus_b.mem_rd_en) begin first_rd = bus_b.mem_addr; break; end
            @(negedge clk); #1;
        end
        chk("clr_mid_restart_addr0", first_rd, 0);

        // ---- u_a: table-driven events ----
        tv[0] = '{4'd3,  4'd5,  1'b1, 'h53, 8};
        tv[1] = '{4'd3,  4'd5,  1'b1, 'h53, 9};
        tv[2] = '{4'd0,  4'd1,  1'b0, 'h10, -128};
        tv[3] = '{4'd2,  4'd2,  1'b1, 'h22, 127};
        tv[4] = '{4'd4,  4'd3,  1'b0, 'h34, -2};
        tv[5] = '{4'd15, 4'd15, 1'b1, 'hFF, -126};
        tv[6] = '{4'd0,  4'd0,  1'b0, 'h00, -1};
        tv[7] = '{4'd2,  4'd2,  1'b0, 'h22, 126};
        @(negedge clk); rst_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_a.ev_x = tv[i].x; bus_a.ev_y = tv[i].y; bus_a.ev_pol = tv[i].pol; bus_a.ev_valid = 1'b1;
            #1;
            chk($sformatf("ev%0d_ready", i), bus_a.ev_ready, 1);
            chk($sformatf("ev%0d_rd", i), {bus_a.mem_rd_en, bus_a.mem_wr_en}, 2);
            chk($sformatf("ev%0d_rd_addr", i), bus_a.mem_addr, tv[i].addr);
            @(negedge clk); #1;
            chk($sformatf("ev%0d_wr", i), {bus_a.ev_ready, bus_a.mem_rd_en, bus_a.mem_wr_en}, 1);
            chk($sformatf("ev%0d_wr_addr", i), bus_a.mem_addr, tv[i].addr);
            chk($sformatf("ev%0d_wdata", i), bus_a.mem_wdata, tv[i].wdata);
        end
        @(negedge clk); bus_a.ev_valid = 1'b0; #1;
        chk("idle_outputs", {bus_a.ev_ready, bus_a.mem_rd_en, bus_a.mem_wr_en}, 0);

        // ---- u_a: clear and event in the same cycle ----
        @(negedge clk);
        bus_a.ev_x = 4'd3; bus_a.ev_y = 4'd5; bus_a.ev_pol = 1'b1; bus_a.ev_valid = 1'b1; clr_a = 1'b1;
        #1;
        chk("clr_vs_ev_ready", bus_a.ev_ready, 0);
        chk("clr_vs_ev_rd", bus_a.mem_rd_en, 0);
        @(negedge clk); clr_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (!(cb_a && bus_a.mem_wr_en && !bus_a.mem_rd_en && !bus_a.ev_ready &&
                  bus_a.mem_addr == i[7:0] && bus_a.mem_wdata == 0)) bad++;
        end
        chk("clr_sweep_bad_cycles", bad, 0);
        @(negedge clk); #1;
        chk("clr_end_busy", cb_a, 0);
        chk("clr_end_ev_granted", bus_a.ev_ready, 1);
        chk("clr_end_ev_addr", bus_a.mem_addr, 'h53);
        @(negedge clk); bus_a.ev_valid = 1'b0; #1;
        chk("clr_end_ev_wdata", bus_a.mem_wdata, 1);
        chk("clr_mem_22_zeroed", mem_a[8'h22], 0);

        // ---- u_a: clear_req during a clear ----
        @(negedge clk);
        bus_a.ev_x = 4'd7; bus_a.ev_y = 4'd7; bus_a.ev_valid = 1'b1; clr_a = 1'b1;
        busy = 0; rdy_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); clr_a = (c == 100); #1;
            if (cb_a) busy++;
            if (c <= 512 && bus_a.ev_ready) rdy_cnt++;
        end
        chk("dbl_clr_busy_cycles", busy, 512);
        chk("dbl_clr_no_grant", rdy_cnt, 0);

        // ---- u_a: reset during the write cycle ----
        @(negedge clk); bus_a.ev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_a.ev_x = 4'd3; bus_a.ev_y = 4'd5; bus_a.ev_pol = 1'b1; bus_a.ev_valid = 1'b1;
        #1;
        chk("rstwr_grant", bus_a.ev_ready, 1);
        @(negedge clk); #1;
        chk("rstwr_in_wr", bus_a.mem_wr_en, 1);
        #1; rst_a = 1'b1; #1;
        chk("rstwr_wr_dropped", bus_a.mem_wr_en, 0);
        chk("rstwr_ready_low", {bus_a.ev_ready, bus_a.mem_rd_en}, 0);
        @(negedge clk); #1;
        chk("rstwr_mem_untouched", mem_a[8'h53], 0);
        @(negedge clk); rst_a = 1'b0; #1;
        chk("rstwr_regrant", bus_a.ev_ready, 1);
        chk("rstwr_regrant_addr", bus_a.mem_addr, 'h53);
        @(negedge clk); bus_a.ev_valid = 1'b0; #1;
        chk("rstwr_regrant_wdata", bus_a.mem_wdata, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
